// File: rtl/forward_tag_pipe_pkg.sv
// Shared pipeline definitions for the forwarding tag tracker.
// Tag entry layout, register-address default and source-operand indices.
package forward_tag_pipe_pkg;

    localparam int RAW_DEF = 5;
    // Tag dst storage width; narrower RAW values are zero-extended into it.
    localparam int RAW_MAX = 8;

    localparam int SRC_RS = 0;
    localparam int SRC_RT = 1;

    typedef struct packed {
        logic               valid;
        logic [RAW_MAX-1:0] dst;
        logic               is_load;
    } tag_t;

endpackage

// File: rtl/fwd_prio_match.sv
// Priority match of one source register against all tracked tags.
// Ports: tags (DEPTH*LANES, index s*LANES+l), src -> hit/stage/lane/is_load.
module fwd_prio_match
    import forward_tag_pipe_pkg::*;
#(
    parameter int LANES = 2,
    parameter int DEPTH = 2,
    parameter int RAW   = RAW_DEF,
    parameter int SW    = 1,
    parameter int LW    = 1
) (
    input  tag_t [DEPTH*LANES-1:0] tags,
    input  logic [RAW-1:0]         src,
    output logic                   hit,
    output logic [SW-1:0]          stage,
    output logic [LW-1:0]          lane,
    output logic                   is_load
);

    logic [RAW_MAX-1:0] src_x;

    // Walk oldest stage first and lowest lane first; later matches
    // overwrite, so the youngest stage and highest lane survive.
    always_comb begin
        hit     = 1'b0;
        stage   = '0;
        lane    = '0;
        is_load = 1'b0;
        src_x   = RAW_MAX'(src);
        for (int s = DEPTH - 1; s >= 0; s--) begin
            for (int l = 0; l < LANES; l++) begin
                if (tags[s*LANES+l].valid &&
                    tags[s*LANES+l].dst == src_x &&
                    src != '0) begin
                    hit     = 1'b1;
                    stage   = SW'(s);
                    lane    = LW'(l);
                    is_load = tags[s*LANES+l].is_load;
                end
            end
        end
    end

endmodule

// File: rtl/forward_tag_pipe.sv
// Tracks post-EX destination tags and selects forwarding sources.
// Ports: EX bundle in, stall/flush/hold controls, fwd_* selects, load-use, count.
module forward_tag_pipe
    import forward_tag_pipe_pkg::*;
#(
    parameter int LANES = 2,
    parameter int DEPTH = 2,
    parameter int RAW   = RAW_DEF,
    localparam int SW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES-1:0]        ex_valid,
    input  logic [LANES-1:0]        ex_regwrite,
    input  logic [LANES-1:0]        ex_is_load,
    input  logic [LANES*RAW-1:0]    ex_dst,
    input  logic [LANES*RAW-1:0]    ex_rs,
    input  logic [LANES*RAW-1:0]    ex_rt,
    input  logic                    ex_stall,
    input  logic                    ex_flush,
    input  logic                    hold_all,
    output logic [2*LANES-1:0]      fwd_hit,
    output logic [2*LANES*SW-1:0]   fwd_stage,
    output logic [2*LANES*LW-1:0]   fwd_lane,
    output logic                    load_use_stall,
    output logic [15:0]             fwd_count
);

    localparam int NSRC = 2 * LANES;

    tag_t [DEPTH*LANES-1:0] tags_q;
    tag_t [DEPTH*LANES-1:0] tags_d;
    logic [15:0]            fwd_count_q;
    logic [15:0]            fwd_count_d;

    logic [RAW-1:0] src_reg [NSRC];
    logic           m_hit   [NSRC];
    logic [SW-1:0]  m_stage [NSRC];
    logic [LW-1:0]  m_lane  [NSRC];
    logic           m_load  [NSRC];

    logic           ex_wr;

    always_comb begin
        tags_d = tags_q;
        ex_wr  = 1'b0;
        if (!hold_all) begin
            for (int s = DEPTH - 1; s >= 1; s--) begin
                for (int l = 0; l < LANES; l++) begin
                    tags_d[s*LANES+l] = tags_q[(s-1)*LANES+l];
                end
            end
            for (int l = 0; l < LANES; l++) begin
                ex_wr = ex_valid[l] && ex_regwrite[l] &&
                        !ex_stall && !ex_flush &&
                        (ex_dst[l*RAW +: RAW] != '0);
                // Bubbles carry all-zero fields so nothing stale survives.
                tags_d[l].valid   = ex_wr;
                tags_d[l].dst     = ex_wr ? RAW_MAX'(ex_dst[l*RAW +: RAW])
                                          : '0;
                tags_d[l].is_load = ex_wr && ex_is_load[l];
            end
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            src_reg[2*l+SRC_RS] = ex_rs[l*RAW +: RAW];
            src_reg[2*l+SRC_RT] = ex_rt[l*RAW +: RAW];
        end
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        fwd_prio_match #(
            .LANES (LANES),
            .DEPTH (DEPTH),
            .RAW   (RAW),
            .SW    (SW),
            .LW    (LW)
        ) u_match (
            .tags    (tags_q),
            .src     (src_reg[i]),
            .hit     (m_hit[i]),
            .stage   (m_stage[i]),
            .lane    (m_lane[i]),
            .is_load (m_load[i])
        );
    end

    // Outputs are forced quiet while reset is held low.
    always_comb begin
        fwd_hit        = '0;
        fwd_stage      = '0;
        fwd_lane       = '0;
        load_use_stall = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (rst) begin
                fwd_hit[i]           = m_hit[i];
                fwd_stage[i*SW +: SW] = m_stage[i];
                fwd_lane[i*LW +: LW]  = m_lane[i];
                if (ex_valid[i/2] && m_hit[i] &&
                    m_stage[i] == '0 && m_load[i]) begin
                    load_use_stall = 1'b1;
                end
            end
        end
    end

    always_comb begin
        fwd_count_d = fwd_count_q;
        if (!hold_all && (|fwd_hit) && fwd_count_q != 16'hFFFF) begin
            fwd_count_d = fwd_count_q + 16'd1;
        end
    end

    assign fwd_count = fwd_count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            tags_q      <= '0;
            fwd_count_q <= '0;
        end else begin
            tags_q      <= tags_d;
            fwd_count_q <= fwd_count_d;
        end
    end

endmodule

// File: tb/tb_forward_tag_pipe.sv
// Randomized and directed bench for forward_tag_pipe.
// Compares against a history-list model of recent EX writes.
module tb_forward_tag_pipe;

    localparam int LANES = 2;
    localparam int DEPTH = 2;
    localparam int RAW   = 5;
    localparam int SW    = 1;
    localparam int LW    = 1;
    localparam int NSRC  = 2 * LANES;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [LANES-1:0]      ex_valid;
    logic [LANES-1:0]      ex_regwrite;
    logic [LANES-1:0]      ex_is_load;
    logic [LANES*RAW-1:0]  ex_dst;
    logic [LANES*RAW-1:0]  ex_rs;
    logic [LANES*RAW-1:0]  ex_rt;
    logic                  ex_stall;
    logic                  ex_flush;
    logic                  hold_all;
    logic [NSRC-1:0]       fwd_hit;
    logic [NSRC*SW-1:0]    fwd_stage;
    logic [NSRC*LW-1:0]    fwd_lane;
    logic                  load_use_stall;
    logic [15:0]           fwd_count;

    forward_tag_pipe #(.LANES(LANES), .DEPTH(DEPTH), .RAW(RAW)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_regwrite    (ex_regwrite),
        .ex_is_load     (ex_is_load),
        .ex_dst         (ex_dst),
        .ex_rs          (ex_rs),
        .ex_rt          (ex_rt),
        .ex_stall       (ex_stall),
        .ex_flush       (ex_flush),
        .hold_all       (hold_all),
        .fwd_hit        (fwd_hit),
        .fwd_stage      (fwd_stage),
        .fwd_lane       (fwd_lane),
        .load_use_stall (load_use_stall),
        .fwd_count      (fwd_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [7:0] dst;
        logic       ld;
    } mt_t;

    // hist[a] = the writes made a+1 advancing cycles ago.
    mt_t hist [DEPTH][LANES];
    int  mcnt;

    logic [NSRC-1:0]    e_hit;
    logic [NSRC*SW-1:0] e_stage;
    logic [NSRC*LW-1:0] e_lane;
    logic               e_lus;

    int  checks   = 0;
    int  failures = 0;
    bit  chk_en   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic void model_eval();
        logic [RAW-1:0] src;
        bit             found;
        int             idx;
        e_hit   = '0;
        e_stage = '0;
        e_lane  = '0;
        e_lus   = 1'b0;
        if (rst) begin
            for (int l = 0; l < LANES; l++) begin
                for (int r = 0; r < 2; r++) begin
                    idx   = 2 * l + r;
                    src   = r ? ex_rt[l*RAW +: RAW] : ex_rs[l*RAW +: RAW];
                    found = 0;
                    if (src != 0) begin
                        for (int a = 0; a < DEPTH && !found; a++) begin
                            for (int n = LANES - 1; n >= 0 && !found; n--) begin
                                if (hist[a][n].v && hist[a][n].dst == 8'(src)) begin
                                    found = 1;
                                    e_hit[idx] = 1'b1;
                                    e_stage[idx*SW +: SW] = SW'(a);
                                    e_lane[idx*LW +: LW]  = LW'(n);
                                    if (a == 0 && hist[a][n].ld && ex_valid[l])
                                        e_lus = 1'b1;
                                end
                            end
                        end
                    end
                end
            end
        end
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            for (int a = 0; a < DEPTH; a++)
                for (int n = 0; n < LANES; n++)
                    hist[a][n] = '0;
            mcnt = 0;
        end else if (!hold_all) begin
            model_eval();
            if (|e_hit && mcnt < 65535) mcnt++;
            for (int a = DEPTH - 1; a >= 1; a--)
                for (int n = 0; n < LANES; n++)
                    hist[a][n] = hist[a-1][n];
            for (int n = 0; n < LANES; n++) begin
                hist[0][n].v   = ex_valid[n] && ex_regwrite[n] && !ex_stall &&
                                 !ex_flush && ex_dst[n*RAW +: RAW] != 0;
                hist[0][n].dst = 8'(ex_dst[n*RAW +: RAW]);
                hist[0][n].ld  = ex_is_load[n];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            model_eval();
            chk("hit",   32'(fwd_hit),        32'(e_hit));
            chk("stage", 32'(fwd_stage),      32'(e_stage));
            chk("lane",  32'(fwd_lane),       32'(e_lane));
            chk("lus",   32'(load_use_stall), 32'(e_lus));
            chk("count", 32'(fwd_count),      32'(mcnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_ex();
        ex_valid    = '0;
        ex_regwrite = '0;
        ex_is_load  = '0;
        ex_dst      = '0;
        ex_rs       = '0;
        ex_rt       = '0;
        ex_stall    = 1'b0;
        ex_flush    = 1'b0;
        hold_all    = 1'b0;
    endtask

    task automatic set_lane(input int l, input bit v, input bit rw,
                            input bit ld, input int d, input int s,
                            input int t);
        ex_valid[l]           = v;
        ex_regwrite[l]        = rw;
        ex_is_load[l]         = ld;
        ex_dst[l*RAW +: RAW]  = RAW'(d);
        ex_rs[l*RAW +: RAW]   = RAW'(s);
        ex_rt[l*RAW +: RAW]   = RAW'(t);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    logic [15:0] cnt_snap;
    logic [NSRC-1:0] hit_snap;

    initial begin
        clr_ex();
        do_reset();
        chk_en = 1;
        chk("rst_hit", 32'(fwd_hit), 0);
        chk("rst_cnt", 32'(fwd_count), 0);

        // lane0 writes r5, then lane1 rs=r5 at stage 0, then stage 1
        set_lane(0, 1, 1, 0, 5, 0, 0);
        step();
        clr_ex();
        set_lane(1, 1, 0, 0, 0, 5, 0);
        #1;
        chk("s1_hit",   32'(fwd_hit[2]), 1);
        chk("s1_stage", 32'(fwd_stage[2*SW +: SW]), 0);
        chk("s1_lane",  32'(fwd_lane[2*LW +: LW]), 0);
        step();
        chk("s1_stage2", 32'(fwd_stage[2*SW +: SW]), 1);
        chk("s1_hit2",   32'(fwd_hit[2]), 1);

        // both lanes write r7 -> lane1 wins
        clr_ex();
        set_lane(0, 1, 1, 0, 7, 0, 0);
        set_lane(1, 1, 1, 0, 7, 0, 0);
        step();
        clr_ex();
        set_lane(0, 1, 0, 0, 0, 7, 0);
        #1;
        chk("s2_hit",  32'(fwd_hit[0]), 1);
        chk("s2_lane", 32'(fwd_lane[0 +: LW]), 1);

        // stage1 lane0 r3 beats stage2 lane1 r3
        clr_ex();
        set_lane(1, 1, 1, 0, 3, 0, 0);
        step();
        clr_ex();
        set_lane(0, 1, 1, 0, 3, 0, 0);
        step();
        clr_ex();
        set_lane(0, 1, 0, 0, 0, 0, 3);
        #1;
        chk("s3_hit",   32'(fwd_hit[1]), 1);
        chk("s3_stage", 32'(fwd_stage[1*SW +: SW]), 0);
        chk("s3_lane",  32'(fwd_lane[1*LW +: LW]), 0);

        // load-use, then a one-cycle stall moves the load to stage 2
        clr_ex();
        set_lane(0, 1, 1, 1, 9, 0, 0);
        step();
        clr_ex();
        set_lane(0, 1, 0, 0, 0, 9, 0);
        #1;
        chk("s4_lus",  32'(load_use_stall), 1);
        chk("s4_hit",  32'(fwd_hit[0]), 1);
        ex_stall = 1'b1;
        step();
        chk("s4_lus2",   32'(load_use_stall), 0);
        chk("s4_stage2", 32'(fwd_stage[0 +: SW]), 1);
        chk("s4_hit2",   32'(fwd_hit[0]), 1);

        // r0 write and flushed write never hit
        clr_ex();
        step();
        step();
        set_lane(0, 1, 1, 0, 0, 0, 0);
        step();
        clr_ex();
        set_lane(0, 1, 0, 0, 0, 0, 0);
        set_lane(1, 1, 1, 0, 11, 0, 0);
        ex_flush = 1'b1;
        step();
        clr_ex();
        set_lane(0, 1, 0, 0, 0, 11, 0);
        #1;
        chk("s5_flush", 32'(fwd_hit), 0);

        // hold_all freezes outputs and count
        clr_ex();
        set_lane(0, 1, 1, 0, 4, 0, 0);
        step();
        clr_ex();
        set_lane(1, 1, 0, 0, 0, 0, 4);
        hold_all = 1'b1;
        #1;
        hit_snap = fwd_hit;
        cnt_snap = fwd_count;
        chk("s5_hold_hit", 32'(fwd_hit[3]), 1);
        for (int i = 0; i < 3; i++) begin
            set_lane(0, 1, 1, 0, 6, 0, 0);
            ex_stall = i[0];
            step();
            chk("s5_hold_h", 32'(fwd_hit), 32'(hit_snap));
            chk("s5_hold_c", 32'(fwd_count), 32'(cnt_snap));
        end

        // randomized phase with occasional reset
        clr_ex();
        for (int c = 0; c < 3000; c++) begin
            for (int l = 0; l < LANES; l++) begin
                set_lane(l, 1'($urandom), 1'($urandom), 1'($urandom),
                         int'($urandom_range(0, 7)),
                         int'($urandom_range(0, 7)),
                         int'($urandom_range(0, 7)));
            end
            ex_stall = ($urandom_range(0, 9) == 0);
            ex_flush = ($urandom_range(0, 9) == 0);
            hold_all = ($urandom_range(0, 7) == 0);
            rst      = ($urandom_range(0, 199) != 0);
            step();
        end
        rst = 1'b1;

        // saturation
        clr_ex();
        do_reset();
        set_lane(0, 1, 1, 0, 5, 0, 0);
        set_lane(1, 1, 0, 0, 0, 5, 0);
        for (int c = 0; c < 70000; c++) step();
        chk("sat", 32'(fwd_count), 32'h0000FFFF);
        rst = 1'b0;
        #1;
        chk("rst_lvl_hit", 32'(fwd_hit), 0);
        step();
        chk("rst_mid_hit", 32'(fwd_hit), 0);
        chk("rst_mid_cnt", 32'(fwd_count), 0);
        chk("rst_mid_lus", 32'(load_use_stall), 0);
        rst = 1'b1;
        step();
        @(negedge clk);
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
